// File: rtl/instr_fetch_unit.sv
// PC register and fetch sequencer: requests one instruction word at a time, holds it
// for the datapath, and commits the next PC (sequential, beq, j) when Advance arrives.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemData,
    output logic [31:0] Instruction,
    output logic [5:0]  Opcode,
    output logic        InstrValid,
    output logic [31:0] PCPlus4,
    input  logic        Advance,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic        FetchFault,
    output logic [31:0] RetiredCount
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] instr, instr_d;
    logic        valid, valid_d;
    logic        fault, fault_d;
    logic [31:0] retired, retired_d;
    logic [15:0] wait_cnt, wait_d;
    logic [31:0] pc_plus4, next_pc, br_off;

    assign pc_plus4 = pc + 32'd4;
    // Word offset of beq, sign-extended and scaled to bytes.
    assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (Jump)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (Branch && Zero)
            next_pc = pc_plus4 + br_off;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            instr    <= 32'd0;
            valid    <= 1'b0;
            fault    <= 1'b0;
            retired  <= 32'd0;
            wait_cnt <= 16'd0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            instr    <= instr_d;
            valid    <= valid_d;
            fault    <= fault_d;
            retired  <= retired_d;
            wait_cnt <= wait_d;
        end
    end

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        instr_d   = instr;
        valid_d   = valid;
        fault_d   = fault;
        retired_d = retired;
        wait_d    = wait_cnt;
        case (state)
            IDLE: state_d = FETCH;
            FETCH: begin
                // A ready response wins even on the last allowed wait cycle.
                if (ImemReady) begin
                    instr_d = ImemData;
                    valid_d = 1'b1;
                    wait_d  = 16'd0;
                    state_d = HOLD;
                end else if (wait_cnt == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else begin
                    wait_d = wait_cnt + 16'd1;
                end
            end
            HOLD: begin
                if (Advance) begin
                    pc_d      = next_pc;
                    valid_d   = 1'b0;
                    retired_d = retired + 32'd1;
                    state_d   = FETCH;
                end
            end
            FAULT: begin
                valid_d = 1'b0;
                fault_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ImemReq      = (state == FETCH);
    assign ImemAddr     = pc;
    assign Instruction  = instr;
    assign Opcode       = instr[31:26];
    assign InstrValid   = valid;
    assign PCPlus4      = pc_plus4;
    assign FetchFault   = fault;
    assign RetiredCount = retired;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- PC register and instruction-fetch sequencer for the MIPS core.
- Sits directly upstream of the single-cycle control decoder and the datapath.
- Issues word reads to instruction memory over a req/ready handshake with variable latency, and holds the fetched instruction stable until the datapath signals Advance.
- Computes the next PC (PC+4, taken beq, j) internally from the held instruction plus the Branch/Zero/Jump feedback, and drives Opcode to the control decoder.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- MAX_WAIT, 16, max consecutive FETCH cycles without ImemReady before a fault (1..65535).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ImemReq  out  1  fetch request to instruction memory.
- ImemAddr  out  32  byte address of fetch (= PC).
- ImemReady  in  1  memory has ImemData valid this cycle.
- ImemData  in  32  fetched instruction word.
- Instruction  out  32  held instruction.
- Opcode  out  6  Instruction[31:26], to control decoder.
- InstrValid  out  1  Instruction/Opcode/PCPlus4 valid.
- PCPlus4  out  32  PC+4 of held instruction.
- Advance  in  1  datapath has consumed the held instruction; commit next PC.
- Branch  in  1  from control: current instruction is beq.
- Zero  in  1  from ALU: beq condition true.
- Jump  in  1  from control: current instruction is j.
- FetchFault  out  1  sticky: memory timeout occurred.
- RetiredCount  out  32  number of accepted Advance events.

Behaviour:
- Reset values (asynchronous, while Reset=1):
  - PC=RESET_PC, state=IDLE.
  - Instruction=0, InstrValid=0, FetchFault=0, RetiredCount=0, wait counter=0.
  - Resulting outputs: ImemReq=0, Opcode=0, PCPlus4=RESET_PC+4.
- States: IDLE, FETCH, HOLD, FAULT.
- Combinational outputs:
  - ImemReq = (state==FETCH).
  - ImemAddr = PC; Opcode = Instruction[31:26]; PCPlus4 = PC+4 (mod 2^32).
- IDLE: unconditionally to FETCH next cycle. This gives one dead cycle after reset release.
- FETCH:
  - ImemReady=1: Instruction<=ImemData, InstrValid<=1, wait counter<=0, go to HOLD.
  - Ready in the same cycle as the first ImemReq assertion is legal. Minimum latency is InstrValid high one cycle after the ready cycle.
  - ImemReady=0: wait counter increments.
  - If the counter reaches MAX_WAIT-1 with ImemReady still 0, go to FAULT and set FetchFault<=1.
- HOLD:
  - Instruction, InstrValid, PC stable.
  - Advance=1: PC<=NextPC, InstrValid<=0, RetiredCount<=RetiredCount+1 (wraps at 2^32), go to FETCH.
  - Advance=0: remain in HOLD.
- NextPC priority:
  - Jump=1: {PCPlus4[31:28], Instruction[25:0], 2'b00}.
  - else Branch&Zero: PCPlus4 + (sign-extended Instruction[15:0] << 2), mod 2^32.
  - else PCPlus4.
  - Jump overrides Branch when both are asserted.
- Advance, Branch, Zero, Jump are ignored outside HOLD. RetiredCount does not change.
- ImemReady outside FETCH is ignored. ImemData is not captured.
- FAULT: ImemReq=0, InstrValid=0, FetchFault=1. Only Reset exits.
- PC wrap: PC=32'hFFFF_FFFC advancing sequentially gives NextPC=0. Negative branch offsets wrap likewise.
- PC[1:0] is always 00 (RESET_PC aligned, all NextPC forms aligned).
- Reset asserted mid-fetch or mid-hold: immediate return to reset values. A pending memory response after reset is ignored because the state is IDLE.

Test Plan:
- Reset with RESET_PC=0x400, then release:
  - Cycle 1: ImemReq=0.
  - Cycle 2: ImemReq=1, ImemAddr=0x400.
  - ImemReady=1 with data 0x8C080004: next cycle InstrValid=1, Opcode=6'b100011, PCPlus4=0x404.
- Sequential: Advance with Branch=Jump=0 → ImemAddr=0x404, InstrValid=0, RetiredCount=1.
- Taken beq: held instruction 0x1000FFFF at PC 0x408, Branch=1, Zero=1, Advance → ImemAddr=0x408. Not-taken (Zero=0) → ImemAddr=0x40C.
- Jump over branch: held instruction 0x08000100 at PC 0x1000_0000, Jump=1, Branch=1, Zero=1, Advance → ImemAddr=0x1000_0400.
- Latency/timeout with MAX_WAIT=4:
  - ImemReady delayed 3 cycles → normal capture.
  - ImemReady never asserted → FetchFault=1 after 4 FETCH cycles, ImemReq=0, Advance ignored.
  - Reset clears the fault.
- Wrap and mid-op reset:
  - RESET_PC=0xFFFFFFFC, fetch+Advance → ImemAddr=0x0.
  - Assert Reset during HOLD → InstrValid=0, PC=RESET_PC; late ImemReady ignored.
